// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: assigns note events to voice slots, reuses held notes,
// prefers free slots and steals the oldest sounding slot when all are busy.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ev_valid,
  input  logic [6:0]              ev_note,
  input  logic [6:0]              ev_vel,
  input  logic                    ev_on,
  input  logic                    panic,
  output logic                    ev_ready,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_vel,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic                    stolen
);

  localparam int                IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_W-1:0]  AGE_MAX  = '1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t            state;
  logic [6:0]        note_q [NUM_VOICES];
  logic [6:0]        vel_q  [NUM_VOICES];
  logic [AGE_W-1:0]  age_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q;

  logic [6:0]        lat_note;
  logic [6:0]        lat_vel;
  logic              lat_on;
  logic [IDX_W-1:0]  idx;

  logic              match_ok, free_ok, old_ok;
  logic [IDX_W-1:0]  match_idx, free_idx, old_idx;
  logic [AGE_W-1:0]  old_age;

  logic [IDX_W-1:0]  tgt;
  logic              steal;

  // Target priority: held copy of the same note, then lowest free slot, then oldest.
  always_comb begin
    tgt   = old_idx;
    steal = 1'b1;
    if (match_ok) begin
      tgt   = match_idx;
      steal = 1'b0;
    end else if (free_ok) begin
      tgt   = free_idx;
      steal = 1'b0;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every slot sees the
  // pre-edge ages/gates when deciding its own update in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gate_q     <= '0;
      voice_trig <= '0;
      stolen     <= 1'b0;
      lat_note   <= '0;
      lat_vel    <= '0;
      lat_on     <= 1'b0;
      idx        <= '0;
      match_ok   <= 1'b0;
      free_ok    <= 1'b0;
      old_ok     <= 1'b0;
      match_idx  <= '0;
      free_idx   <= '0;
      old_idx    <= '0;
      old_age    <= '0;
      // NOTE: the slot arrays are reset because their contents are visible
      // outputs that must read zero straight out of reset.
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      voice_trig <= '0;
      stolen     <= 1'b0;
      if (panic) begin
        gate_q <= '0;
        for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= '0;
        state  <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (ev_valid) begin
              lat_note <= ev_note;
              lat_vel  <= ev_vel;
              lat_on   <= ev_on && (ev_vel != 7'd0);
              idx      <= '0;
              match_ok <= 1'b0;
              free_ok  <= 1'b0;
              old_ok   <= 1'b0;
              state    <= SCAN;
            end
          end
          SCAN: begin
            if (gate_q[idx]) begin
              if (!match_ok && note_q[idx] == lat_note) begin
                match_ok  <= 1'b1;
                match_idx <= idx;
              end
              // Strictly greater keeps the lowest index on equal ages.
              if (!old_ok || age_q[idx] > old_age) begin
                old_ok  <= 1'b1;
                old_idx <= idx;
                old_age <= age_q[idx];
              end
            end else if (!free_ok) begin
              free_ok  <= 1'b1;
              free_idx <= idx;
            end
            if (idx == LAST_IDX) state <= COMMIT;
            else                 idx   <= idx + 1'b1;
          end
          COMMIT: begin
            if (lat_on) begin
              for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == tgt) begin
                  note_q[i]     <= lat_note;
                  vel_q[i]      <= lat_vel;
                  gate_q[i]     <= 1'b1;
                  age_q[i]      <= '0;
                  voice_trig[i] <= 1'b1;
                end else if (gate_q[i] && age_q[i] != AGE_MAX) begin
                  age_q[i] <= age_q[i] + 1'b1;
                end
              end
              stolen <= steal;
            end else if (match_ok) begin
              // Note and velocity stay put so the envelope can release on them.
              gate_q[match_idx] <= 1'b0;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign ev_ready   = (state == IDLE);
  assign voice_gate = gate_q;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_note[7*g +: 7] = note_q[g];
    assign voice_vel[7*g +: 7]  = vel_q[g];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus randomized
// note traffic compared against a slot-table reference model.
module tb_voice_allocator;
  localparam int NV      = 4;
  localparam int AGE_W   = 4;
  localparam int AGE_MAX = (1 << AGE_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0, ev_valid = 1'b0, ev_on = 1'b0, panic = 1'b0;
  logic [6:0] ev_note = '0, ev_vel = '0;
  logic ev_ready, stolen;
  logic [7*NV-1:0] voice_note, voice_vel;
  logic [NV-1:0]   voice_gate, voice_trig;

  int checks = 0, errors = 0;

  // Reference model: one entry per slot.
  int m_note [NV];
  int m_vel  [NV];
  int m_age  [NV];
  bit m_gate [NV];
  logic [NV-1:0] exp_trig;
  logic          exp_stolen;

  // Values captured by drive_event.
  logic [NV-1:0] cap_trig, cap_trig2;
  logic          cap_stolen, cap_stolen2, cap_ready, cap_ready_scan;

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(AGE_W)) dut (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_note(ev_note), .ev_vel(ev_vel),
    .ev_on(ev_on), .panic(panic), .ev_ready(ev_ready), .voice_note(voice_note),
    .voice_vel(voice_vel), .voice_gate(voice_gate), .voice_trig(voice_trig), .stolen(stolen)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7*NV-1:0] pack_note();
    logic [7*NV-1:0] r;
    for (int i = 0; i < NV; i++) r[7*i +: 7] = 7'(m_note[i]);
    return r;
  endfunction

  function automatic logic [7*NV-1:0] pack_vel();
    logic [7*NV-1:0] r;
    for (int i = 0; i < NV; i++) r[7*i +: 7] = 7'(m_vel[i]);
    return r;
  endfunction

  function automatic logic [NV-1:0] pack_gate();
    logic [NV-1:0] r;
    for (int i = 0; i < NV; i++) r[i] = m_gate[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0; m_gate[i] = 0;
    end
  endtask

  task automatic model_panic();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 0; m_age[i] = 0;
    end
  endtask

  task automatic model_event(input bit on, input int note, input int vel);
    int match = -1, free = -1, old = -1, tgt;
    exp_trig   = '0;
    exp_stolen = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (m_gate[i]) begin
        if (match < 0 && m_note[i] == note) match = i;
        if (old < 0 || m_age[i] > m_age[old]) old = i;
      end else if (free < 0) free = i;
    end
    if (on && vel != 0) begin
      tgt = (match >= 0) ? match : ((free >= 0) ? free : old);
      exp_stolen = (match < 0 && free < 0);
      for (int i = 0; i < NV; i++)
        if (i != tgt && m_gate[i] && m_age[i] < AGE_MAX) m_age[i]++;
      m_note[tgt] = note; m_vel[tgt] = vel; m_gate[tgt] = 1; m_age[tgt] = 0;
      exp_trig[tgt] = 1'b1;
    end else if (match >= 0) begin
      m_gate[match] = 0;
    end
  endtask

  // Drives one event, optionally with a stray ev_valid during SCAN, and
  // captures the pulse outputs in the cycle after commit and the cycle after that.
  task automatic drive_event(input bit on, input int note, input int vel, input bit inject);
    int n = 0;
    @(negedge clk);
    while (!ev_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ev_ready) begin
      errors++;
      $display("FAIL ready_timeout: ev_ready=%b after %0d cycles, required 1", ev_ready, n);
    end
    ev_valid = 1'b1; ev_on = on; ev_note = 7'(note); ev_vel = 7'(vel);
    @(posedge clk);
    @(negedge clk);
    cap_ready_scan = ev_ready;
    if (inject) begin
      ev_on = 1'b1; ev_note = 7'(note) ^ 7'h55; ev_vel = 7'd99;
    end else ev_valid = 1'b0;
    for (int k = 0; k <= NV; k++) begin
      @(posedge clk);
      if (k == 0) #1 ev_valid = 1'b0;
    end
    @(negedge clk);
    cap_trig = voice_trig; cap_stolen = stolen; cap_ready = ev_ready;
    @(negedge clk);
    cap_trig2 = voice_trig; cap_stolen2 = stolen;
    model_event(on, note, vel);
  endtask

  task automatic do_panic();
    @(negedge clk);
    panic = 1'b1;
    @(posedge clk);
    @(negedge clk);
    panic = 1'b0;
    model_panic();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #17;
    checks++;
    if ({voice_gate, voice_note, voice_vel, voice_trig, stolen} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gate=%h note=%h vel=%h trig=%h stolen=%b, required all 0",
               voice_gate, voice_note, voice_vel, voice_trig, stolen);
    end
    checks++;
    if (ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", ev_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_first_note();
    drive_event(1'b1, 60, 100, 1'b0);
    checks++;
    if (cap_ready_scan !== 1'b0) begin
      errors++;
      $display("FAIL first_busy: ev_ready during scan=%b, required 0", cap_ready_scan);
    end
    checks++;
    if (voice_gate[0] !== 1'b1 || voice_note[6:0] !== 7'd60 || voice_vel[6:0] !== 7'd100) begin
      errors++;
      $display("FAIL first_slot0: gate=%b note=%0d vel=%0d, required 1/60/100",
               voice_gate[0], voice_note[6:0], voice_vel[6:0]);
    end
    checks++;
    if (cap_trig !== 4'b0001 || cap_stolen !== 1'b0 || cap_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_pulse: trig=%b stolen=%b ready=%b, required 0001/0/1",
               cap_trig, cap_stolen, cap_ready);
    end
    checks++;
    if (cap_trig2 !== 4'b0000 || cap_stolen2 !== 1'b0) begin
      errors++;
      $display("FAIL first_pulse_width: trig=%b stolen=%b one cycle later, required 0000/0",
               cap_trig2, cap_stolen2);
    end
  endtask

  task automatic test_steal();
    int notes[5] = '{60, 64, 67, 72, 76};
    do_panic();
    for (int i = 0; i < 4; i++) drive_event(1'b1, notes[i], 90 + i, 1'b0);
    checks++;
    if (voice_note !== {7'd72, 7'd67, 7'd64, 7'd60} || voice_gate !== 4'b1111) begin
      errors++;
      $display("FAIL steal_fill: note=%h gate=%b, required slots 60,64,67,72 all held",
               voice_note, voice_gate);
    end
    drive_event(1'b1, notes[4], 80, 1'b0);
    checks++;
    if (cap_trig !== 4'b0001 || cap_stolen !== 1'b1 || voice_note[6:0] !== 7'd76) begin
      errors++;
      $display("FAIL steal_oldest: trig=%b stolen=%b slot0=%0d, required 0001/1/76",
               cap_trig, cap_stolen, voice_note[6:0]);
    end
    drive_event(1'b1, 81, 70, 1'b0);
    checks++;
    if (cap_trig !== 4'b0010 || cap_stolen !== 1'b1 || voice_note[13:7] !== 7'd81) begin
      errors++;
      $display("FAIL steal_next: trig=%b stolen=%b slot1=%0d, required 0010/1/81",
               cap_trig, cap_stolen, voice_note[13:7]);
    end
  endtask

  task automatic test_note_off();
    do_panic();
    drive_event(1'b1, 60, 100, 1'b0);
    drive_event(1'b1, 64, 100, 1'b0);
    drive_event(1'b1, 67, 100, 1'b0);
    drive_event(1'b1, 64, 0, 1'b0);
    checks++;
    if (voice_gate !== 4'b0101 || voice_note[13:7] !== 7'd64 || cap_trig !== '0 || cap_stolen !== 1'b0) begin
      errors++;
      $display("FAIL off_vel0: gate=%b slot1=%0d trig=%b stolen=%b, required 0101/64/0000/0",
               voice_gate, voice_note[13:7], cap_trig, cap_stolen);
    end
    drive_event(1'b1, 48, 30, 1'b0);
    checks++;
    if (cap_trig !== 4'b0010 || cap_stolen !== 1'b0 || voice_note[13:7] !== 7'd48) begin
      errors++;
      $display("FAIL off_reuse: trig=%b stolen=%b slot1=%0d, required 0010/0/48",
               cap_trig, cap_stolen, voice_note[13:7]);
    end
  endtask

  task automatic test_retrigger();
    logic [7*NV-1:0] note_before;
    do_panic();
    drive_event(1'b1, 60, 100, 1'b0);
    drive_event(1'b1, 64, 80, 1'b0);
    note_before = voice_note;
    drive_event(1'b1, 60, 50, 1'b0);
    checks++;
    if (voice_vel[6:0] !== 7'd50 || cap_trig !== 4'b0001 || cap_stolen !== 1'b0
        || voice_note !== note_before || voice_gate !== 4'b0011 || voice_vel[13:7] !== 7'd80) begin
      errors++;
      $display("FAIL retrig: vel0=%0d trig=%b stolen=%b gate=%b, required 50/0001/0/0011",
               voice_vel[6:0], cap_trig, cap_stolen, voice_gate);
    end
    // Slot0 age reset means slot1 is now the steal victim once all four are held.
    drive_event(1'b1, 70, 10, 1'b0);
    drive_event(1'b1, 71, 10, 1'b0);
    drive_event(1'b1, 72, 10, 1'b0);
    checks++;
    if (cap_trig !== 4'b0010 || cap_stolen !== 1'b1) begin
      errors++;
      $display("FAIL retrig_age: trig=%b stolen=%b, required 0010/1", cap_trig, cap_stolen);
    end
  endtask

  task automatic test_unmatched_and_drop();
    logic [7*NV-1:0] n0, v0;
    logic [NV-1:0]   g0;
    n0 = voice_note; v0 = voice_vel; g0 = voice_gate;
    drive_event(1'b0, 10, 64, 1'b0);
    checks++;
    if ({voice_note, voice_vel, voice_gate} !== {n0, v0, g0} || cap_trig !== '0 || cap_stolen !== 1'b0) begin
      errors++;
      $display("FAIL unmatched_off: gate=%b trig=%b stolen=%b, required unchanged %b/0000/0",
               voice_gate, cap_trig, cap_stolen, g0);
    end
    drive_event(1'b0, 70, 64, 1'b1);
    checks++;
    if ({voice_gate, voice_note, voice_vel} !== {pack_gate(), pack_note(), pack_vel()}
        || cap_trig !== '0 || cap_trig2 !== '0) begin
      errors++;
      $display("FAIL scan_drop: gate=%b trig=%b/%b, required %b/0000/0000",
               voice_gate, cap_trig, cap_trig2, pack_gate());
    end
  endtask

  task automatic test_panic_scan();
    logic [NV-1:0] trig_acc = '0;
    do_panic();
    drive_event(1'b1, 40, 100, 1'b0);
    drive_event(1'b1, 41, 100, 1'b0);
    drive_event(1'b1, 42, 100, 1'b0);
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd90; ev_vel = 7'd90;
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    @(negedge clk);
    panic = 1'b1;
    @(posedge clk);
    @(negedge clk);
    panic = 1'b0;
    model_panic();
    checks++;
    if (voice_gate !== '0 || ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL panic_scan: gate=%b ready=%b, required 0000/1", voice_gate, ev_ready);
    end
    for (int k = 0; k < NV + 3; k++) begin
      @(negedge clk);
      trig_acc |= voice_trig;
    end
    checks++;
    if (voice_gate !== '0 || trig_acc !== '0 || voice_note !== pack_note()) begin
      errors++;
      $display("FAIL panic_discard: gate=%b trig_seen=%b note=%h, required 0000/0000/%h",
               voice_gate, trig_acc, voice_note, pack_note());
    end
  endtask

  task automatic test_panic_idle();
    logic [NV-1:0] trig_acc = '0;
    @(negedge clk);
    panic = 1'b1; ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd33; ev_vel = 7'd33;
    @(posedge clk);
    @(negedge clk);
    panic = 1'b0; ev_valid = 1'b0;
    model_panic();
    for (int k = 0; k < NV + 3; k++) begin
      @(negedge clk);
      trig_acc |= voice_trig;
    end
    checks++;
    if (voice_gate !== '0 || trig_acc !== '0 || ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL panic_idle: gate=%b trig_seen=%b ready=%b, required 0000/0000/1",
               voice_gate, trig_acc, ev_ready);
    end
  endtask

  task automatic test_reset_mid();
    drive_event(1'b1, 55, 55, 1'b0);
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd56; ev_vel = 7'd56;
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({voice_gate, voice_note, voice_vel, voice_trig, stolen} !== '0 || ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: gate=%b note=%h ready=%b, required all 0 and ready 1",
               voice_gate, voice_note, ev_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NV + 2) @(negedge clk);
    checks++;
    if (voice_gate !== '0 || voice_note !== '0) begin
      errors++;
      $display("FAIL reset_mid_lost: gate=%b note=%h, required 0", voice_gate, voice_note);
    end
  endtask

  task automatic test_random();
    for (int e = 0; e < 300; e++) begin
      bit on;
      int note, vel;
      if ($urandom_range(0, 39) == 0) do_panic();
      on   = ($urandom_range(0, 2) != 0);
      note = 50 + $urandom_range(0, 7);
      vel  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 127);
      drive_event(on, note, vel, $urandom_range(0, 7) == 0);
      checks++;
      if ({voice_gate, voice_note, voice_vel} !== {pack_gate(), pack_note(), pack_vel()}) begin
        errors++;
        $display("FAIL rand_state[%0d]: gate=%b note=%h vel=%h, required %b %h %h", e,
                 voice_gate, voice_note, voice_vel, pack_gate(), pack_note(), pack_vel());
      end
      checks++;
      if (cap_trig !== exp_trig || cap_stolen !== exp_stolen || cap_ready !== 1'b1
          || cap_trig2 !== '0 || cap_stolen2 !== 1'b0) begin
        errors++;
        $display("FAIL rand_pulse[%0d]: trig=%b stolen=%b ready=%b next=%b/%b, required %b/%b/1 then 0",
                 e, cap_trig, cap_stolen, cap_ready, cap_trig2, cap_stolen2, exp_trig, exp_stolen);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_note();
    test_steal();
    test_note_off();
    test_retrigger();
    test_unmatched_and_drop();
    test_panic_scan();
    test_panic_idle();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
